word_assembler: RTL
===================

WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 SHALL have parameter LEN_DATA, default 256, output word width in bits.
REQ-002 SHALL have parameter LEN_BEAT, default 32, input beat width in bits; LEN_DATA SHALL be an integer multiple of LEN_BEAT, with BEATS = LEN_DATA/LEN_BEAT >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of in-progress and held words.
REQ-006 SHALL have port in_data  input  LEN_BEAT  beat payload.
REQ-007 SHALL have port in_valid  input  1  beat offered.
REQ-008 SHALL have port in_ready  output  1  beat can be accepted.
REQ-009 SHALL have port out_data  output  LEN_DATA  assembled word, feeds a downstream 2-to-1 word mux operand.
REQ-010 SHALL have port out_valid  output  1  out_data holds a complete word.
REQ-011 SHALL have port out_ready  input  1  consumer takes word.

Function
REQ-012 SHALL count a beat as accepted on an edge where in_valid=1 and in_ready=1; a word SHALL transfer on an edge where out_valid=1 and out_ready=1.
REQ-013 SHALL place the k-th accepted beat of a word (k=0..BEATS-1) at out_data bits [k*LEN_BEAT +: LEN_BEAT] (first beat in LSBs).
REQ-014 SHALL keep a beat counter 0..BEATS-1 that increments per accepted beat and wraps to 0 when the final beat (count BEATS-1) is accepted.
REQ-015 SHALL implement states ASSEMBLE (collecting beats, in_ready=1) and HOLD (complete word parked in assembly register, in_ready=0).
REQ-016 SHALL drive in_ready from registered state only; no combinational path from in_valid, out_ready or clear to in_ready.
REQ-017 On final-beat acceptance in ASSEMBLE with out_valid=0, or out_valid=1 and out_ready=1 on the same edge: SHALL load the complete word into the output register and set out_valid=1 after that edge; state stays ASSEMBLE.
REQ-018 On final-beat acceptance in ASSEMBLE with out_valid=1 and out_ready=0: SHALL go to HOLD.
REQ-019 In HOLD, on an edge with out_ready=1: SHALL move the parked word to the output register (out_valid stays 1), return to ASSEMBLE with counter 0.
REQ-020 SHALL clear out_valid after an output transfer when no new word is loaded on the same edge.
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 Latency: out_valid SHALL rise on the edge accepting the final beat (visible the following cycle) when the output register is free; sustained throughput SHALL be one word per BEATS cycles with out_ready tied high.
REQ-023 clear=1 SHALL take priority over all handshakes on that edge: counter to 0, state to ASSEMBLE, out_valid to 0, any beat or word offered that edge discarded; out_data value SHALL be retained (not zeroed).
REQ-024 Non-final beats SHALL be accepted in ASSEMBLE regardless of out_valid/out_ready.

Reset
REQ-025 While rst_n=0: counter=0, state=ASSEMBLE, out_valid=0, in_ready=1, out_data=0, assembly register=0; takes effect without a clock edge.
REQ-026 Reset asserted mid-word or in HOLD SHALL discard all partial and parked data; first beat after release SHALL be beat 0 of a new word.

Verification
REQ-027 Defaults, out_ready=1, beats 0x00000001..0x00000008 on consecutive cycles -> out_valid=1 for one cycle starting the cycle after beat 8, out_data=0x00000008_00000007_..._00000001.
REQ-028 out_ready=0, two words streamed (beats 0x1..0x8 then 0x11..0x18) -> first word presented stable, in_ready=0 after 16th beat (HOLD); raise out_ready one cycle -> second word presented next cycle, in_ready=1.
REQ-029 clear=1 after 3 beats of a word -> next 8 beats 0xA0..0xA7 form one word with 0xA0 in LSBs; no word from the 3 discarded beats.
REQ-030 clear=1 on same edge as a final beat with out_ready=1 -> out_valid=0 next cycle, counter=0, word discarded.
REQ-031 rst_n low asynchronously (between edges) while in HOLD -> out_valid=0, in_ready=1, out_data=0 immediately; after release 8 beats produce one correct word.
REQ-032 Random in_valid/out_ready (50%) over 1000 words -> scoreboard: every word matches beat order, none lost or duplicated, out_data never changes while stalled.

Source files
------------

// File: rtl/word_assembler_if.sv
// word_assembler_if: beat-in / word-out handshake bundle for word_assembler.
//   in_data   [LEN_BEAT]  beat payload            (producer -> assembler)
//   in_valid              beat offered            (producer -> assembler)
//   in_ready              beat can be accepted    (assembler -> producer)
//   out_data  [LEN_DATA]  assembled word          (assembler -> consumer)
//   out_valid             out_data is complete    (assembler -> consumer)
//   out_ready             consumer takes word     (consumer -> assembler)
// Modport slave is the assembler's view; master is the environment's view.
interface word_assembler_if #(
  parameter int unsigned LEN_DATA = 256,
  parameter int unsigned LEN_BEAT = 32
);
  logic [LEN_BEAT-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LEN_DATA-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/word_assembler.sv
// word_assembler: packs BEATS = LEN_DATA/LEN_BEAT consecutive accepted beats
// into one LEN_DATA word, first beat in the LSBs.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (clears all state and out_data)
//   clear  synchronous flush of partial and parked words; out_data retained
//   bus    word_assembler_if.slave (in_* beat side, out_* word side)
// A completed word goes straight to the output register when it is free (or
// being emptied on the same edge); otherwise it parks in the assembly
// register (HOLD, in_ready=0) until the consumer takes the current word.
module word_assembler #(
  parameter int unsigned LEN_DATA = 256,
  parameter int unsigned LEN_BEAT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  word_assembler_if.slave  bus
);

  localparam int unsigned BEATS = LEN_DATA / LEN_BEAT;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if ((LEN_DATA % LEN_BEAT) != 0 || BEATS < 2) begin : g_bad_params
    $error("word_assembler: LEN_DATA must be a multiple (>=2) of LEN_BEAT");
  end

  typedef enum logic {
    ASSEMBLE,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_DATA-1:0] asm_q, asm_d;
  logic [LEN_DATA-1:0] out_q, out_d;
  logic                ov_q, ov_d;

  logic                beat_acc;
  logic                out_xfer;
  logic [LEN_DATA-1:0] asm_merged;

  // in_ready depends on the state register only.
  assign bus.in_ready  = (state_q == ASSEMBLE);
  assign bus.out_data  = out_q;
  assign bus.out_valid = ov_q;

  assign beat_acc = bus.in_valid && (state_q == ASSEMBLE);
  assign out_xfer = ov_q && bus.out_ready;

  // Assembly register with the current beat dropped into its slot.
  always_comb begin
    asm_merged = asm_q;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        asm_merged[k*LEN_BEAT +: LEN_BEAT] = bus.in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    out_d   = out_q;
    ov_d    = ov_q;

    if (clear) begin
      state_d = ASSEMBLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      unique case (state_q)
        ASSEMBLE: begin
          if (out_xfer) ov_d = 1'b0;
          if (beat_acc) begin
            asm_d = asm_merged;
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              if (!ov_q || bus.out_ready) begin
                out_d = asm_merged;
                ov_d  = 1'b1;
              end else begin
                state_d = HOLD;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // out_valid is necessarily 1 here; swap in the parked word.
          if (bus.out_ready) begin
            out_d   = asm_q;
            ov_d    = 1'b1;
            cnt_d   = '0;
            state_d = ASSEMBLE;
          end
        end
        default: state_d = ASSEMBLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSEMBLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

endmodule
